// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and FSM encoding for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned REG_ADDR_WIDTH = 5;
   localparam int unsigned REG_SIZE       = 1 << REG_ADDR_WIDTH;
   localparam int unsigned ZERO_REG       = 0;
   localparam int unsigned WAIT_CNT_WIDTH = 4;

   typedef enum logic {
      ARB   = 1'b0,
      STEAL = 1'b1
   } state_e;

endpackage

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single RF write port between pipeline WB (priority) and a multi-cycle unit.
// Writes land one cycle after grant; M is backpressured via m_ready_o, P via a stolen-slot stall_o.
module rf_wb_arbiter #(
   parameter int unsigned DATA_WIDTH     = rf_wb_arbiter_pkg::DATA_WIDTH,
   parameter int unsigned REG_ADDR_WIDTH = rf_wb_arbiter_pkg::REG_ADDR_WIDTH,
   parameter int unsigned MAX_WAIT       = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      p_valid_i,
   input  logic [REG_ADDR_WIDTH-1:0] p_rd_i,
   input  logic [DATA_WIDTH-1:0]     p_data_i,
   input  logic                      m_valid_i,
   input  logic [REG_ADDR_WIDTH-1:0] m_rd_i,
   input  logic [DATA_WIDTH-1:0]     m_data_i,
   output logic                      m_ready_o,
   output logic                      stall_o,
   output logic                      reg_write_o,
   output logic [REG_ADDR_WIDTH-1:0] write_reg_o,
   output logic [DATA_WIDTH-1:0]     write_data_o
);

   import rf_wb_arbiter_pkg::*;

   localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST = WAIT_CNT_WIDTH'(MAX_WAIT - 1);
   localparam logic [REG_ADDR_WIDTH-1:0] RD_ZERO   = REG_ADDR_WIDTH'(ZERO_REG);

   state_e                    state_q, state_d;
   logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
   logic                      grant_p, grant_m;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ARB;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // wait_cnt counts consecutive lost arbitrations while M is waiting.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ARB: begin
            if (m_valid_i && p_valid_i) begin
               if (wait_cnt_q == WAIT_LAST) begin
                  state_d    = STEAL;
                  wait_cnt_d = '0;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end else begin
               wait_cnt_d = '0;
            end
         end
         STEAL: begin
            state_d    = ARB;
            wait_cnt_d = '0;
         end
         default: begin
            state_d    = ARB;
            wait_cnt_d = '0;
         end
      endcase
   end

   // stall_o decodes the state flop alone, so it is glitch-free and drops on async reset.
   always_comb begin
      grant_p   = 1'b0;
      grant_m   = 1'b0;
      m_ready_o = 1'b0;
      stall_o   = 1'b0;
      case (state_q)
         ARB: begin
            grant_p   = p_valid_i;
            grant_m   = m_valid_i & ~p_valid_i;
            m_ready_o = m_valid_i & ~p_valid_i;
         end
         STEAL: begin
            stall_o   = 1'b1;
            grant_m   = m_valid_i;
            m_ready_o = m_valid_i;
         end
         default: begin
            stall_o   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         reg_write_o  <= 1'b0;
         write_reg_o  <= '0;
         write_data_o <= '0;
      end else if (grant_p) begin
         reg_write_o  <= (p_rd_i != RD_ZERO);
         write_reg_o  <= p_rd_i;
         write_data_o <= p_data_i;
      end else if (grant_m) begin
         reg_write_o  <= (m_rd_i != RD_ZERO);
         write_reg_o  <= m_rd_i;
         write_data_o <= m_data_i;
      end else begin
         reg_write_o  <= 1'b0;
      end
   end

   // The pipeline honours stall_o, so P never shows up during a stolen slot.
   a_no_p_in_steal : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == STEAL) |-> !p_valid_i);

endmodule
